alu_share_ctrl: RTL and testbench

Sequencer and arbiter that shares the single 16-bit ALU between two requesters (req0: execute stage, req1: PC/address unit) through valid/ready handshakes. It captures one operation, drives the ALU for one cycle, and registers the result. It owns the architectural flag register (V, N, Z) and updates it according to opcode class. It also latches a sticky halt on HLT.

---
 rtl/alu_share_ctrl.sv | 111 +++++++++++
 tb/tb_alu_share_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 16-bit ALU between two valid/ready requesters, owns {V,N,Z} flags and a sticky halt
// Ports:
//   clk, rst (sync, active-low)
//   req0_*/req1_* : valid/ready request with opcode[3:0], op1[15:0], op2[15:0]
//   alu_opcode/alu_op1/alu_op2 out, alu_result/alu_ovfl in : external combinational ALU
//   resp_valid/resp_ready/resp_id/resp_data : registered result handshake
//   flags {V,N,Z}, halted
// Build option: define ALU_SHARE_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module alu_share_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_op1,
  input  logic [15:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_op1,
  input  logic [15:0] req1_op2,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic [2:0]  flags,
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] op1_q, op1_d;
  logic [15:0] op2_q, op2_d;
  logic        id_q, id_d;
  logic        resp_id_q, resp_id_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic [2:0]  flags_q, flags_d;
  logic        halted_q, halted_d;
  logic        rr_pick1, grant1, open, hs, iss, z_cls, nv_cls;
`ifdef ALU_SHARE_RR_EN
  assign rr_pick1 = ~last_grant_q;
`else
  // last_grant is still tracked here; fixed priority simply masks it off
  assign rr_pick1 = 1'b0 & ~last_grant_q;
`endif
  // with no valid request the grant rests on req0, so one ready is always high while open
  assign grant1     = req1_valid & (~req0_valid | rr_pick1);
  assign open       = (state_q == IDLE) & ~halted_q & rst;
  assign req0_ready = open & ~grant1;
  assign req1_ready = open & grant1;
  assign hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign iss        = (state_q == ISSUE);
  assign z_cls      = op_q inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
  assign nv_cls     = op_q inside {4'h0, 4'h1};
  // the op register only changes on accept, so it doubles as the held ALU drive
  assign alu_opcode = op_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign flags      = flags_q;
  assign halted     = halted_q;
  always_comb begin
    state_d      = state_q == IDLE  ? (hs ? ISSUE : IDLE) :
                   state_q == ISSUE ? RESP :
                   (resp_ready ? IDLE : RESP);
    last_grant_d = hs ? grant1 : last_grant_q;
    id_d         = hs ? grant1 : id_q;
    op_d         = hs ? (grant1 ? req1_opcode : req0_opcode) : op_q;
    op1_d        = hs ? (grant1 ? req1_op1 : req0_op1) : op1_q;
    op2_d        = hs ? (grant1 ? req1_op2 : req0_op2) : op2_q;
    resp_id_d    = iss ? id_q : resp_id_q;
    resp_data_d  = iss ? alu_result : resp_data_q;
    flags_d      = {iss & nv_cls ? alu_ovfl       : flags_q[2],
                    iss & nv_cls ? alu_result[15] : flags_q[1],
                    iss & z_cls  ? (alu_result == 16'h0) : flags_q[0]};
    halted_d     = halted_q | (iss & (op_q == 4'hF));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      flags_q      <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      flags_q      <= flags_d;
      halted_q     <= halted_d;
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: table-driven and randomized checks of alu_share_ctrl against a transaction-level model
module tb_alu_share_ctrl;
`ifdef ALU_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_opcode = 0, req1_opcode = 0, alu_opcode;
  logic [15:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic [15:0] alu_op1, alu_op2, alu_result, resp_data;
  logic alu_ovfl, resp_valid, resp_ready = 0, resp_id, halted;
  logic [2:0] flags;
  int n_chk = 0, n_fail = 0, r1_cnt = 0;
  logic mon_en = 0;
  logic p_v[2];
  logic [3:0] p_o[2];
  logic [15:0] p_a[2], p_b[2];
  logic m_last, m_halted;
  logic [2:0] m_flags;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result), .alu_ovfl(alu_ovfl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .flags(flags), .halted(halted)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] rot;
    rot = {a, a} >> b[3:0];
    case (o)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a ^ b;
      4'h4: return a << b[3:0];
      4'h5: return $signed(a) >>> b[3:0];
      4'h6: return rot[15:0];
      4'hA: return {a[15:8], b[7:0]};
      4'hB: return {b[7:0], a[7:0]};
      default: return a & b;
    endcase
  endfunction

  function automatic logic alu_ov(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s, d;
    s = a + b;
    d = a - b;
    case (o)
      4'h0: return (a[15] == b[15]) && (s[15] != a[15]);
      4'h1: return (a[15] != b[15]) && (d[15] != a[15]);
      default: return a[0];
    endcase
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_op1, alu_op2);
  assign alu_ovfl   = alu_ov(alu_opcode, alu_op1, alu_op2);

  always @(negedge clk) if (mon_en && req1_ready) r1_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    req0_valid = p_v[0]; req0_opcode = p_o[0]; req0_op1 = p_a[0]; req0_op2 = p_b[0];
    req1_valid = p_v[1]; req1_opcode = p_o[1]; req1_op1 = p_a[1]; req1_op2 = p_b[1];
  endtask

  task automatic set_req(input int r, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    p_v[r] = 1'b1; p_o[r] = o; p_a[r] = a; p_b[r] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_flags", flags, 0);
      chk("rst_halted", halted, 0);
    end
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_op1", alu_op1, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    p_v[0] = 0; p_v[1] = 0;
    drive();
    m_last = 1'b1; m_halted = 1'b0; m_flags = 3'b000;
  endtask

  // One complete transaction from the current IDLE cycle through the response handshake
  task automatic xact(input int stall, output logic gid, output logic [15:0] gd, output logic [2:0] gf);
    logic [3:0] o;
    logic [15:0] a, b, r;
    logic ov, h0;
    @(negedge clk);
    drive();
    gid = (p_v[0] && p_v[1]) ? (RR ? ~m_last : 1'b0) : p_v[1];
    o = p_o[gid]; a = p_a[gid]; b = p_b[gid];
    #1;
    chk("grant_ready0", req0_ready, gid == 1'b0);
    chk("grant_ready1", req1_ready, gid == 1'b1);
    @(posedge clk);
    #1;
    p_v[gid] = 1'b0;
    drive();
    m_last = gid;
    h0 = m_halted;
    @(negedge clk);
    chk("issue_readies", {req0_ready, req1_ready}, 0);
    chk("issue_resp_valid", resp_valid, 0);
    chk("issue_alu_opcode", alu_opcode, o);
    chk("issue_alu_op1", alu_op1, a);
    chk("issue_alu_op2", alu_op2, b);
    chk("issue_halted", halted, h0);
    r = alu_fn(o, a, b);
    ov = alu_ov(o, a, b);
    if (o inside {[4'h0:4'h2], [4'h4:4'h6]}) m_flags[0] = (r == 16'h0);
    if (o <= 4'h1) begin m_flags[2] = ov; m_flags[1] = r[15]; end
    if (o == 4'hF) m_halted = 1'b1;
    @(negedge clk);
    resp_ready = (stall == 0);
    gid = resp_id; gd = resp_data; gf = flags;
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      chk("resp_valid", resp_valid, 1);
      chk("resp_id", resp_id, m_last);
      chk("resp_data", resp_data, r);
      chk("resp_flags", flags, m_flags);
      chk("resp_halted", halted, m_halted);
      chk("resp_readies", {req0_ready, req1_ready}, 0);
      if (i == stall) resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic id; logic [3:0] op; logic [15:0] a; logic [15:0] b;
    int stall; logic [15:0] ed; logic [2:0] ef;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic gid;
    logic [15:0] gd;
    logic [2:0] gf;
    int r;
    vecs[0] = '{1'b0, 4'h0, 16'h7FFF, 16'h0001, 0, 16'h8000, 3'b110};
    vecs[1] = '{1'b0, 4'h2, 16'h1234, 16'h1234, 0, 16'h0000, 3'b111};
    vecs[2] = '{1'b1, 4'hA, 16'h5555, 16'h00AB, 0, 16'h55AB, 3'b111};
    vecs[3] = '{1'b1, 4'h1, 16'h0005, 16'h0005, 0, 16'h0000, 3'b001};
    vecs[4] = '{1'b0, 4'h1, 16'h0001, 16'h0002, 0, 16'hFFFF, 3'b010};
    vecs[5] = '{1'b0, 4'h0, 16'h0001, 16'h0002, 5, 16'h0003, 3'b000};
    p_v[0] = 0; p_v[1] = 0;
    p_o[0] = 0; p_o[1] = 0; p_a[0] = 0; p_a[1] = 0; p_b[0] = 0; p_b[1] = 0;
    do_reset();
    foreach (vecs[i]) begin
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      xact(vecs[i].stall, gid, gd, gf);
      chk($sformatf("vec%0d_id", i), gid, vecs[i].id);
      chk($sformatf("vec%0d_data", i), gd, vecs[i].ed);
      chk($sformatf("vec%0d_flags", i), gf, vecs[i].ef);
    end
    do_reset();
    set_req(0, 4'h0, 16'h0010, 16'h0001);
    set_req(1, 4'h0, 16'h0020, 16'h0002);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xact(0, gid, gd, gf);
      chk($sformatf("both_valid_id%0d", i), gid, RR ? i % 2 : 0);
      set_req(gid, 4'h0, 16'($urandom), 16'($urandom));
    end
    mon_en = 1'b0;
    chk("req1_ready_seen", r1_cnt != 0, RR);
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 2; k++)
        if (!p_v[k] && $urandom_range(0, 1) == 1)
          set_req(k, 4'($urandom_range(0, 14)), 16'($urandom), 16'($urandom));
      if (!p_v[0] && !p_v[1]) begin
        r = $urandom_range(0, 1);
        set_req(r, 4'($urandom_range(0, 14)), 16'($urandom), 16'($urandom));
      end
      xact($urandom_range(0, 2), gid, gd, gf);
    end
    p_v[0] = 0;
    set_req(1, 4'hF, 16'h0000, 16'h0000);
    xact(0, gid, gd, gf);
    chk("hlt_id", gid, 1);
    chk("halted_after_hlt", halted, 1);
    set_req(0, 4'h0, 16'h0001, 16'h0001);
    drive();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halted_ready0", req0_ready, 0);
      chk("halted_resp_valid", resp_valid, 0);
    end
    do_reset();
    set_req(1, 4'hF, 16'h0000, 16'h0000);
    @(negedge clk);
    drive();
    #1;
    chk("midrst_ready1", req1_ready, 1);
    @(posedge clk);
    #1;
    p_v[1] = 0;
    drive();
    @(negedge clk);
    chk("midrst_issue_opcode", alu_opcode, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_resp_data", resp_data, 0);
    chk("midrst_alu_opcode", alu_opcode, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_after_resp_valid", resp_valid, 0);
      chk("midrst_after_ready0", req0_ready, 1);
      chk("midrst_after_halted", halted, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
